// File: rtl/bus_pkg.sv
// Shared bus definitions: requester count, select width, source indices and the
// drive arbiter's state encoding.
package bus_pkg;

  localparam int NUM_SRC = 24;
  localparam int SEL_W   = 5;

  localparam int R0     = 0;
  localparam int R1     = 1;
  localparam int R2     = 2;
  localparam int R3     = 3;
  localparam int R4     = 4;
  localparam int R5     = 5;
  localparam int R6     = 6;
  localparam int R7     = 7;
  localparam int R8     = 8;
  localparam int R9     = 9;
  localparam int R10    = 10;
  localparam int R11    = 11;
  localparam int R12    = 12;
  localparam int R13    = 13;
  localparam int R14    = 14;
  localparam int R15    = 15;
  localparam int HI     = 16;
  localparam int LO     = 17;
  localparam int ZHI    = 18;
  localparam int ZLO    = 19;
  localparam int PC     = 20;
  localparam int MDR    = 21;
  localparam int INPORT = 22;
  localparam int CSIGN  = 23;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } arb_state_e;

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin picker: first set request at or above 'start', wrapping at N-1.
// Purely combinational so any scheduler can register its result as it likes.
module bus_rr_pick
  import bus_pkg::*;
#(
  parameter int N = NUM_SRC,
  parameter int W = SEL_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         found
);

  localparam logic [W:0] N_EXT = N[W:0];

  logic [N-1:0] rotReq;
  logic [N-1:0] rotHot;
  logic [W-1:0] pos;
  logic [W:0]   sum;

  // Rotate so 'start' sits at bit 0, find the lowest set bit, then undo the rotation.
  always_comb begin
    rotReq = N'({req, req} >> start);
    found  = 1'b0;
    pos    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotReq[i]) begin
        found = 1'b1;
        pos   = W'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, pos};
    if (sum >= N_EXT) begin
      sum = sum - N_EXT;
    end
    idx    = sum[W-1:0];
    rotHot = found ? (N'(1) << pos) : '0;
    onehot = N'(({rotHot, rotHot} << start) >> N);
  end

endmodule

// File: rtl/bus_drive_arbiter.sv
// Shared CPU bus owner: round-robin grant among the bus sources with an optional
// hold limit and a dead gap between owners so two sources never drive together.
module bus_drive_arbiter
  import bus_pkg::*;
#(
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               preempt
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int TURN_W = (TURNAROUND < 2) ? 1 : $clog2(TURNAROUND + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               preempt_q, preempt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic [SEL_W-1:0]   last_q, last_d;

  logic [SEL_W-1:0]   startIdx;
  logic [NUM_SRC-1:0] pickGnt;
  logic [SEL_W-1:0]   pickIdx;
  logic               pickFound;
  logic               ownerReq;
  logic               othersReq;
  logic               doArb;
  logic               dropOwner;

  // Search begins just past the last owner, so that owner is the last to be considered.
  assign startIdx  = (last_q == LAST_IDX) ? '0 : last_q + SEL_W'(1);
  assign ownerReq  = |(req & gnt_q);
  assign othersReq = |(req & ~gnt_q);

  bus_rr_pick #(
    .N (NUM_SRC),
    .W (SEL_W)
  ) u_pick (
    .req    (req),
    .start  (startIdx),
    .onehot (pickGnt),
    .idx    (pickIdx),
    .found  (pickFound)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    turn_d    = turn_q;
    last_d    = last_q;
    doArb     = 1'b0;
    dropOwner = 1'b0;

    unique case (state_q)
      IDLE: doArb = 1'b1;
      OWN: begin
        // A release wins over a simultaneous hold-limit condition, so preempt stays low.
        if (!ownerReq) begin
          dropOwner = 1'b1;
        end else if (MAX_HOLD != 0 && hold_q == HOLD_W'(MAX_HOLD) && othersReq) begin
          dropOwner = 1'b1;
          preempt_d = 1'b1;
        end else if (MAX_HOLD != 0 && hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      TURN: begin
        if (turn_q == TURN_W'(TURNAROUND)) begin
          doArb = 1'b1;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (dropOwner) begin
      if (TURNAROUND == 0) begin
        doArb = 1'b1;
      end else begin
        state_d = TURN;
        gnt_d   = '0;
        busy_d  = 1'b0;
        turn_d  = TURN_W'(1);
      end
    end

    if (doArb) begin
      if (pickFound) begin
        state_d = OWN;
        gnt_d   = pickGnt;
        sel_d   = pickIdx;
        busy_d  = 1'b1;
        last_d  = pickIdx;
        hold_d  = HOLD_W'(1);
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
      turn_q    <= '0;
      last_q    <= LAST_IDX;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      last_q    <= last_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule
